// File: rtl/player_action_fsm.sv
// Player action state machine: stand/walk/crouch/shield/jump/punch driven by game ticks.
// Optional PLAYER_AIR_CONTROL_EN: left/right steer pos_x and facing while airborne.
module player_action_fsm #(
    parameter int unsigned X_MIN           = 0,
    parameter int unsigned X_MAX           = 512,
    parameter int unsigned X_INIT          = 100,
    parameter int unsigned WALK_STEP       = 4,
    parameter int unsigned JUMP_FRAMES     = 16,
    parameter int unsigned JUMP_STEP       = 6,
    parameter int unsigned PUNCH_FRAMES    = 8,
    parameter int unsigned PUNCH_HIT_FRAME = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_punch,
    input  logic       btn_shield,
    output logic [6:0] action,
    output logic [9:0] pos_x,
    output logic [7:0] jump_h,
    output logic       punch_hit
);

    localparam int unsigned JW = $clog2(JUMP_FRAMES + 1);
    localparam int unsigned PW = $clog2(PUNCH_FRAMES + 1);

    localparam logic [JW-1:0] JumpLast  = JW'(JUMP_FRAMES - 1);
    localparam logic [JW-1:0] JumpHalf  = JW'(JUMP_FRAMES / 2);
    localparam logic [PW-1:0] PunchLast = PW'(PUNCH_FRAMES - 1);
    localparam logic [PW-1:0] PunchPreHit = PW'(PUNCH_HIT_FRAME - 1);

    typedef enum logic [2:0] {
        StStand, StWalk, StCrouch, StShield, StJump, StPunch
    } state_e;

    state_e        state;
    state_e        sel_state;
    logic [JW-1:0] jump_cnt;
    logic [PW-1:0] punch_cnt;
    logic          punch_prev;
    logic          punch_edge;
    logic          go_left;
    logic          go_right;
    logic [9:0]    pos_dec;
    logic [9:0]    pos_inc;

    function automatic logic [5:0] onehot(input state_e s);
        case (s)
            StWalk:   onehot = 6'b000001;
            StCrouch: onehot = 6'b000010;
            StShield: onehot = 6'b000100;
            StJump:   onehot = 6'b001000;
            StPunch:  onehot = 6'b010000;
            default:  onehot = 6'b100000;
        endcase
    endfunction

    always_comb begin
        punch_edge = btn_punch & ~punch_prev;
        go_left    = btn_left & ~btn_right;
        go_right   = btn_right & ~btn_left;

        if (punch_edge)              sel_state = StPunch;
        else if (btn_up)             sel_state = StJump;
        else if (btn_shield)         sel_state = StShield;
        else if (btn_down)           sel_state = StCrouch;
        else if (go_left | go_right) sel_state = StWalk;
        else                         sel_state = StStand;

        // Saturating moves computed one bit wider so the wall test cannot wrap
        pos_dec = ({1'b0, pos_x} < 11'(X_MIN) + 11'(WALK_STEP)) ? 10'(X_MIN)
                                                                 : pos_x - 10'(WALK_STEP);
        pos_inc = ({1'b0, pos_x} + 11'(WALK_STEP) > 11'(X_MAX)) ? 10'(X_MAX)
                                                                 : pos_x + 10'(WALK_STEP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StStand;
            action     <= 7'b0100000;
            pos_x      <= 10'(X_INIT);
            jump_h     <= '0;
            punch_hit  <= 1'b0;
            jump_cnt   <= '0;
            punch_cnt  <= '0;
            punch_prev <= 1'b1;
        end else begin
            punch_hit <= 1'b0;
            if (tick) begin
                punch_prev <= btn_punch;
                case (state)
                    StJump: begin
                        if (jump_cnt == JumpLast) begin
                            jump_cnt    <= '0;
                            jump_h      <= '0;
                            state       <= StStand;
                            action[5:0] <= onehot(StStand);
                        end else begin
                            jump_cnt <= jump_cnt + 1'b1;
                            jump_h   <= (jump_cnt < JumpHalf) ? jump_h + 8'(JUMP_STEP)
                                                              : jump_h - 8'(JUMP_STEP);
                        end
`ifdef PLAYER_AIR_CONTROL_EN
                        if (go_left) begin
                            pos_x     <= pos_dec;
                            action[6] <= 1'b1;
                        end else if (go_right) begin
                            pos_x     <= pos_inc;
                            action[6] <= 1'b0;
                        end
`endif
                    end
                    StPunch: begin
                        if (punch_cnt == PunchLast) begin
                            punch_cnt   <= '0;
                            state       <= StStand;
                            action[5:0] <= onehot(StStand);
                        end else begin
                            punch_cnt <= punch_cnt + 1'b1;
                        end
                        if (punch_cnt == PunchPreHit) punch_hit <= 1'b1;
                    end
                    default: begin
                        state       <= sel_state;
                        action[5:0] <= onehot(sel_state);
                        jump_cnt    <= '0;
                        punch_cnt   <= '0;
                        jump_h      <= '0;
                        if (sel_state == StWalk) begin
                            if (go_left) begin
                                pos_x     <= pos_dec;
                                action[6] <= 1'b1;
                            end else begin
                                pos_x     <= pos_inc;
                                action[6] <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_player_action_fsm.sv
// Directed bench for player_action_fsm: each tick is followed by an idle cycle,
// expectations queued on drive and checked one edge later.
module tb_player_action_fsm;

    localparam logic [5:0] B_N = 6'b000000;
    localparam logic [5:0] B_L = 6'b100000;
    localparam logic [5:0] B_R = 6'b010000;
    localparam logic [5:0] B_U = 6'b001000;
    localparam logic [5:0] B_D = 6'b000100;
    localparam logic [5:0] B_P = 6'b000010;
    localparam logic [5:0] B_S = 6'b000001;

    localparam logic [5:0] A_WALK   = 6'b000001;
    localparam logic [5:0] A_CROUCH = 6'b000010;
    localparam logic [5:0] A_SHIELD = 6'b000100;
    localparam logic [5:0] A_JUMP   = 6'b001000;
    localparam logic [5:0] A_PUNCH  = 6'b010000;
    localparam logic [5:0] A_STAND  = 6'b100000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0;
    logic       btn_down = 1'b0, btn_punch = 1'b0, btn_shield = 1'b0;
    logic [6:0] action;
    logic [9:0] pos_x;
    logic [7:0] jump_h;
    logic       punch_hit;

    typedef struct {
        string      tag;
        logic [6:0] action;
        logic [9:0] pos;
        logic [7:0] jh;
        logic       hit;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic       face;
    logic [9:0] pos;
    logic [7:0] eh;

    player_action_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_punch  (btn_punch),
        .btn_shield (btn_shield),
        .action     (action),
        .pos_x      (pos_x),
        .jump_h     (jump_h),
        .punch_hit  (punch_hit)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] act(input logic f, input logic [5:0] c);
        return {f, c};
    endfunction

    task automatic set_btns(input logic [5:0] b);
        {btn_left, btn_right, btn_up, btn_down, btn_punch, btn_shield} = b;
    endtask

    task automatic push(input string tag, input logic [6:0] a, input logic [9:0] p,
                        input logic [7:0] h, input logic hit);
        exp_t e;
        e.tag = tag; e.action = a; e.pos = p; e.jh = h; e.hit = hit;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        e = sb.pop_front();
        vectors++;
        assert (action === e.action) else begin
            miscompares++;
            $error("FAIL %s action got %b want %b", e.tag, action, e.action);
        end
        vectors++;
        assert (pos_x === e.pos) else begin
            miscompares++;
            $error("FAIL %s pos_x got %0d want %0d", e.tag, pos_x, e.pos);
        end
        vectors++;
        assert (jump_h === e.jh) else begin
            miscompares++;
            $error("FAIL %s jump_h got %0d want %0d", e.tag, jump_h, e.jh);
        end
        vectors++;
        assert (punch_hit === e.hit) else begin
            miscompares++;
            $error("FAIL %s punch_hit got %b want %b", e.tag, punch_hit, e.hit);
        end
    endtask

    // One tick edge then one idle edge; outputs must hold and punch_hit must drop.
    task automatic tk(input string tag, input logic [5:0] b, input logic [6:0] a,
                      input logic [9:0] p, input logic [7:0] h, input logic hit);
        set_btns(b);
        tick = 1'b1;
        push(tag, a, p, h, hit);
        @(posedge clk);
        #1;
        tick = 1'b0;
        check();
        push({tag, "_idle"}, a, p, h, 1'b0);
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic rst_step(input string tag, input logic [5:0] b);
        set_btns(b);
        rst  = 1'b1;
        tick = 1'b1;
        push(tag, 7'b0100000, 10'd100, 8'd0, 1'b0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        tick = 1'b0;
        check();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_step("reset", B_R);
        face = 1'b0;
        pos  = 10'd100;

        for (int i = 1; i <= 5; i++) begin
            pos = pos + 10'd4;
            tk($sformatf("walk_r%0d", i), B_R, act(1'b0, A_WALK), pos, 8'd0, 1'b0);
        end
        pos = 10'd116;
        tk("walk_l", B_L, act(1'b1, A_WALK), pos, 8'd0, 1'b0);
        tk("stand_face_l", B_N, act(1'b1, A_STAND), pos, 8'd0, 1'b0);

        for (int i = 1; i <= 98; i++) begin
            pos = pos + 10'd4;
            tk($sformatf("walk_far%0d", i), B_R, act(1'b0, A_WALK), pos, 8'd0, 1'b0);
        end
        for (int i = 1; i <= 3; i++)
            tk($sformatf("wall_r%0d", i), B_R, act(1'b0, A_WALK), 10'd512, 8'd0, 1'b0);
        pos  = 10'd512;
        face = 1'b0;
        tk("stand_wall", B_N, act(face, A_STAND), pos, 8'd0, 1'b0);

        tk("jump_entry", B_U, act(face, A_JUMP), pos, 8'd0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
`ifdef PLAYER_AIR_CONTROL_EN
            pos  = pos - 10'd4;
            face = 1'b1;
`endif
            eh = (k == 16) ? 8'd0 : (k <= 8) ? 8'(6 * k) : 8'(48 - 6 * (k - 8));
            tk($sformatf("jump_t%0d", k), B_D | B_L,
               act(face, (k == 16) ? A_STAND : A_JUMP), pos, eh, 1'b0);
        end

        tk("crouch", B_D, act(face, A_CROUCH), pos, 8'd0, 1'b0);
        tk("shield_over_down", B_S | B_D, act(face, A_SHIELD), pos, 8'd0, 1'b0);
        tk("left_right_cancel", B_L | B_R, act(face, A_STAND), pos, 8'd0, 1'b0);

        tk("punch_entry", B_P, act(face, A_PUNCH), pos, 8'd0, 1'b0);
        for (int k = 1; k <= 19; k++)
            tk($sformatf("punch_hold%0d", k), B_P,
               act(face, (k >= 8) ? A_STAND : A_PUNCH), pos, 8'd0, (k == 3));

        tk("release", B_N, act(face, A_STAND), pos, 8'd0, 1'b0);
        tk("punch_priority", B_P | B_U | B_S, act(face, A_PUNCH), pos, 8'd0, 1'b0);
        for (int k = 1; k <= 8; k++)
            tk($sformatf("punch2_%0d", k), B_U | B_S | B_D,
               act(face, (k == 8) ? A_STAND : A_PUNCH), pos, 8'd0, (k == 3));

        rst_step("reset2", B_N);
        face = 1'b0;
        pos  = 10'd100;
        for (int i = 1; i <= 26; i++) begin
            pos = (i >= 25) ? 10'd0 : pos - 10'd4;
            tk($sformatf("wall_l%0d", i), B_L, act(1'b1, A_WALK), pos, 8'd0, 1'b0);
        end

        rst_step("reset3", B_N);
        face = 1'b0;
        pos  = 10'd100;
        tk("jump2_entry", B_U, act(face, A_JUMP), pos, 8'd0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
`ifdef PLAYER_AIR_CONTROL_EN
            pos  = pos - 10'd4;
            face = 1'b1;
`endif
            tk($sformatf("jump2_t%0d", k), B_L, act(face, A_JUMP), pos, 8'(6 * k), 1'b0);
        end
        rst_step("reset_mid_jump", B_L | B_P);
        tk("punch_held_thru_rst", B_P, act(1'b0, A_STAND), 10'd100, 8'd0, 1'b0);
        tk("punch_release", B_N, act(1'b0, A_STAND), 10'd100, 8'd0, 1'b0);
        tk("punch_after_rst", B_P, act(1'b0, A_PUNCH), 10'd100, 8'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
